// File: rtl/sram_port0_arbiter_if.sv
// Request/response channel for one requester of the SRAM port-0 arbiter.
// The requester side uses the master modport, the arbiter the slave modport.
interface sram_port0_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [NUM_WMASKS-1:0] wmask;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;

  modport master (
    output valid, we, wmask, addr, wdata,
    input  ready, rsp_valid
  );

  modport slave (
    input  valid, we, wmask, addr, wdata,
    output ready, rsp_valid
  );
endinterface

// File: rtl/sram_port0_arbiter.sv
// Two-requester arbiter and sequencer for the read/write port (port 0) of a
// 1RW1R SRAM macro. One request is granted per cycle, the macro inputs are
// registered on the handshake edge, and a response pulse is returned to the
// owning requester two cycles after the handshake.
module sram_port0_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_WMASKS  = 4,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  sram_port0_arbiter_if.slave   a,
  sram_port0_arbiter_if.slave   b,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    is_read;
  } issue_t;

  req_id_t prio;
  logic    grant_a;
  logic    grant_b;
  logic    fire;

  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  issue_t stage1;
  issue_t stage2;
  logic   a_rsp_q;
  logic   b_rsp_q;

  // Pick the winner: a lone requester always wins, contention is settled by
  // the priority pointer in round-robin mode or in favour of A otherwise.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a.valid && b.valid) begin
      if (ROUND_ROBIN && (prio == REQ_B)) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else if (a.valid) begin
      grant_a = 1'b1;
    end else if (b.valid) begin
      grant_b = 1'b1;
    end
  end

  assign a.ready = grant_a & ~rst0;
  assign b.ready = grant_b & ~rst0;
  assign fire    = a.ready | b.ready;

  assign sel_we    = grant_b ? b.we    : a.we;
  assign sel_wmask = grant_b ? b.wmask : a.wmask;
  assign sel_addr  = grant_b ? b.addr  : a.addr;
  assign sel_wdata = grant_b ? b.wdata : a.wdata;

  // Priority pointer flips to the other requester after every grant.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      prio <= REQ_A;
    end else if (a.ready) begin
      prio <= REQ_B;
    end else if (b.ready) begin
      prio <= REQ_A;
    end
  end

  // Macro input registers: loaded on a handshake, otherwise the chip is
  // deselected while address, data and mask keep their last values.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
      addr0  <= '0;
      din0   <= '0;
    end else if (fire) begin
      csb0   <= 1'b0;
      web0   <= ~sel_we;
      wmask0 <= sel_we ? sel_wmask : '0;
      addr0  <= sel_addr;
      din0   <= sel_wdata;
    end else begin
      csb0 <= 1'b1;
      web0 <= 1'b1;
    end
  end

  // Two-deep issue pipeline tracking who owns each in-flight operation.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      stage1 <= '0;
      stage2 <= '0;
    end else begin
      stage1 <= '{valid: fire, id: (grant_b ? REQ_B : REQ_A), is_read: ~sel_we};
      stage2 <= stage1;
    end
  end

  // Retire stage 2: pulse the owner's response and capture read data.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      a_rsp_q   <= 1'b0;
      b_rsp_q   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      a_rsp_q <= stage2.valid && (stage2.id == REQ_A);
      b_rsp_q <= stage2.valid && (stage2.id == REQ_B);
      if (stage2.valid && stage2.is_read) begin
        rsp_rdata <= dout0;
      end
    end
  end

  assign a.rsp_valid = a_rsp_q;
  assign b.rsp_valid = b_rsp_q;

endmodule

// File: doc/sram_port0_arbiter.md
# sram_port0_arbiter

Two-requester arbiter and sequencer for the read/write port (port 0) of the 1RW1R SRAM macro. It accepts read and write requests from two independent requesters A and B over valid/ready channels. Each cycle it grants at most one request, using round-robin or fixed priority. It drives the macro's registered port-0 inputs and returns a per-requester response with fixed latency. Port 1 (read-only) is outside this block's scope.

## Interface
- ADDR_WIDTH, 8, macro address width
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte write-mask width (DATA_WIDTH/8)
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority with A over B

Ports:
- clk0  in  1  single clock; the macro's clk0 is tied to it
- rst0  in  1  synchronous, active-high reset
- a_valid, b_valid  in  1  request valid
- a_ready, b_ready  out  1  request accepted this cycle
- a_we, b_we  in  1  1 = write, 0 = read
- a_wmask, b_wmask  in  NUM_WMASKS  byte enables; write only
- a_addr, b_addr  in  ADDR_WIDTH  word address
- a_wdata, b_wdata  in  DATA_WIDTH  write data
- a_rsp_valid, b_rsp_valid  out  1  one-cycle response pulse (read data or write ack)
- rsp_rdata  out  DATA_WIDTH  read data, shared; meaningful only with a read response
- csb0  out  1  to macro; active-low chip select
- web0  out  1  to macro; active-low write enable
- wmask0  out  NUM_WMASKS  to macro
- addr0  out  ADDR_WIDTH  to macro
- din0  out  DATA_WIDTH  to macro
- dout0  in  DATA_WIDTH  from macro

## Operation
- Grant (combinational from valids and priority pointer):
  - Only one valid: that requester wins.
  - Both valid, ROUND_ROBIN=1: the requester that did not win the most recent contested-or-uncontested grant wins.
  - Both valid, ROUND_ROBIN=0: A wins.
- x_ready = grant_x & ~rst0. The valid-to-ready path is combinational. Requesters must hold valid and payload stable until ready.
- Priority pointer updates on every grant to point at the other requester. Reset value favours A.
- Handshake at posedge t registers the macro inputs:
  - csb0=0, web0=~we, addr0=addr, din0=wdata.
  - wmask0 = we ? wmask : 0.
- Cycle with no grant: csb0=1, web0=1. addr0, din0 and wmask0 hold their previous values.
- Issue pipeline: 2-stage shift register of {valid, requester id, is_read}. It accepts one request per cycle, so back-to-back grants are allowed with full throughput.
- Stage 2 leaving the pipe at posedge t+2:
  - Pulses rsp_valid for its requester during cycle t+2..t+3.
  - On a read, loads rsp_rdata from dout0. On a write, rsp_rdata holds its previous value.
- Responses have no backpressure. Requesters must always accept them.
- Write with wmask=0: still issued (csb0=0, web0=0) and still acknowledged. The memory is unchanged.
- Read-after-write to the same address, back-to-back (write granted at t, read at t+1): the read returns the new data, because the macro writes on negedge t+1 and reads on negedge t+2.

## Timing
- Reset values: a_ready=b_ready=0, a_rsp_valid=b_rsp_valid=0, rsp_rdata=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0. Pipeline cleared; pointer favours A.
- Request-to-response latency: handshake at posedge t → macro samples inputs at posedge t+1 → response valid after posedge t+2.
- Throughput is 1 op/cycle. The two requesters alternate under sustained dual contention in round-robin mode.
- dout0 is sampled at posedge t+2. The macro's hold time covers this. The behavioural macro model drives X on dout0 at each posedge, so the bench inserts #1 transport delay on dout0.
- Reset asserted mid-operation:
  - In-flight responses are dropped, with no rsp_valid.
  - csb0 goes high at the first reset edge.
  - A macro operation already sampled may still complete.
- Simultaneous A and B write to the same address in one cycle is impossible, because one grant is made per cycle. The later grant's data wins.

## Test plan
- Reset, then A writes 0xDEADBEEF to addr 0x10 with wmask=0xF, then reads addr 0x10 → a_ready for 1 cycle each. Responses on a_rsp_valid at handshake+2; read response has rsp_rdata=0xDEADBEEF. b_rsp_valid never pulses.
- A and B hold reads of 0x01 and 0x02 asserted for 6 cycles, ROUND_ROBIN=1 → grants A,B,A,B,A,B. Responses alternate with rdata mem[0x01], mem[0x02].
- Same stimulus with ROUND_ROBIN=0 → A granted every cycle; b_ready stays 0.
- Write 0x11223344 to 0x20, then partial write 0xAABBCCDD with wmask=0x5 granted back-to-back, then read 0x20 in the next cycle → rsp_rdata=0x11BB33DD, arriving 2 cycles after the read handshake.
- Write with wmask=0 to 0x30, which holds 0x12345678 → write ack pulses; a subsequent read returns 0x12345678.
- Assert rst0 for 1 cycle while two reads are in flight → no rsp_valid for either; csb0=1 after the reset edge; a fresh read after reset returns correct data with 2-cycle latency.
